// File: rtl/ysyx_22041207_div.sv
// 64-bit restoring divider, signed/unsigned, with flush and fixed latency.
// Divide-by-zero and signed overflow skip the iteration loop entirely.
//
// state | meaning
// IDLE  | waiting for a request (div_ready high once the result pulse is gone)
// BUSY  | one restoring step per cycle, 64 steps
// DONE  | sign-correct and publish the result on the following edge
module ysyx_22041207_div (
    input  logic        clk,
    input  logic        rst,
    input  logic        div_valid,
    input  logic        flush,
    input  logic        div_signed,
    input  logic [63:0] dividend,
    input  logic [63:0] divisor,
    output logic        div_ready,
    output logic        out_valid,
    output logic [63:0] quotient,
    output logic [63:0] remainder
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t       state, state_nxt;
    logic [127:0] acc;
    logic [63:0]  dvs_q;
    logic         q_neg, r_neg;
    logic [6:0]   cnt;

    logic         accept, div_zero, ovf;
    logic [63:0]  dvd_abs, dvs_abs;
    logic         no_borrow;
    logic [63:0]  diff;
    logic [127:0] acc_step;
    logic [63:0]  q_fin, r_fin;

    assign accept   = div_valid && div_ready && !flush;
    assign div_zero = (divisor == 64'd0);
    assign ovf      = div_signed && (dividend == 64'h8000_0000_0000_0000) && (divisor == '1);
    assign dvd_abs  = (div_signed && dividend[63]) ? -dividend : dividend;
    assign dvs_abs  = (div_signed && divisor[63]) ? -divisor : divisor;

    // Shifted partial remainder is 65 bits wide: acc[127] is its carry-out.
    assign no_borrow = (acc[127:63] >= {1'b0, dvs_q});
    assign diff      = acc[126:63] - dvs_q;
    assign acc_step  = no_borrow ? {diff, acc[62:0], 1'b1} : {acc[126:0], 1'b0};

    assign q_fin = q_neg ? -acc[63:0] : acc[63:0];
    assign r_fin = r_neg ? -acc[127:64] : acc[127:64];

    assign div_ready = (state == IDLE) && !out_valid;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = (div_zero || ovf) ? DONE : BUSY;
            BUSY: begin
                if (flush)                state_nxt = IDLE;
                else if (cnt == 7'd63)    state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= 7'd0;
            acc       <= 128'd0;
            dvs_q     <= 64'd0;
            q_neg     <= 1'b0;
            r_neg     <= 1'b0;
            out_valid <= 1'b0;
            quotient  <= 64'd0;
            remainder <= 64'd0;
        end else begin
            out_valid <= (state == DONE) && !flush;
            if ((state == DONE) && !flush) begin
                quotient  <= q_fin;
                remainder <= r_fin;
            end
            if (accept) begin
                cnt   <= 7'd0;
                dvs_q <= dvs_abs;
                // Special cases preload the final answer with no sign correction.
                if (div_zero) begin
                    acc   <= {dividend, 64'hFFFF_FFFF_FFFF_FFFF};
                    q_neg <= 1'b0;
                    r_neg <= 1'b0;
                end else if (ovf) begin
                    acc   <= {64'd0, dividend};
                    q_neg <= 1'b0;
                    r_neg <= 1'b0;
                end else begin
                    acc   <= {64'd0, dvd_abs};
                    q_neg <= div_signed && (dividend[63] ^ divisor[63]);
                    r_neg <= div_signed && dividend[63];
                end
            end else if (state == BUSY) begin
                cnt <= cnt + 7'd1;
                acc <= acc_step;
            end
        end
    end

endmodule

// File: tb/tb_ysyx_22041207_div.sv
// Self-checking bench for ysyx_22041207_div: directed cases plus random
// operands against an arithmetic reference model.
module tb_ysyx_22041207_div;

    logic        clk = 1'b0;
    logic        rst, div_valid, flush, div_signed;
    logic [63:0] dividend, divisor;
    logic        div_ready, out_valid;
    logic [63:0] quotient, remainder;

    int passed = 0;
    int total  = 0;
    logic [63:0] prev_q, prev_r;

    ysyx_22041207_div dut (
        .clk       (clk),
        .rst       (rst),
        .div_valid (div_valid),
        .flush     (flush),
        .div_signed(div_signed),
        .dividend  (dividend),
        .divisor   (divisor),
        .div_ready (div_ready),
        .out_valid (out_valid),
        .quotient  (quotient),
        .remainder (remainder)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    function automatic void model(input logic [63:0] a, input logic [63:0] b, input logic s,
                                  output logic [63:0] q, output logic [63:0] r, output int lat);
        longint sa, sb;
        sa = a;
        sb = b;
        lat = 1;
        if (b == 64'd0) begin
            q = '1;
            r = a;
        end else if (s && a == 64'h8000_0000_0000_0000 && b == '1) begin
            q = a;
            r = 64'd0;
        end else begin
            lat = 65;
            if (s) begin
                q = sa / sb;
                r = sa % sb;
            end else begin
                q = a / b;
                r = a % b;
            end
        end
    endfunction

    task automatic run_op(input logic [63:0] a, input logic [63:0] b, input logic s, input string tag);
        logic [63:0] eq, er;
        int lat, k;
        bit found;
        model(a, b, s, eq, er, lat);
        @(negedge clk);
        check({tag, "_ready_before"}, 64'(div_ready), 64'd1);
        dividend = a; divisor = b; div_signed = s; div_valid = 1'b1;
        @(posedge clk);
        #1;
        div_valid = 1'b0;
        dividend = {$urandom, $urandom};
        divisor  = {$urandom, $urandom};
        div_signed = 1'($urandom);
        k = 0;
        found = 0;
        while (k < 200 && !found) begin
            @(posedge clk);
            k++;
            @(negedge clk);
            if (out_valid) found = 1;
            else if (k == 30) begin
                check({tag, "_hold_q"}, quotient, prev_q);
                check({tag, "_hold_r"}, remainder, prev_r);
                check({tag, "_busy_notready"}, 64'(div_ready), 64'd0);
            end
        end
        check({tag, "_done_seen"}, 64'(found), 64'd1);
        check({tag, "_latency"}, 64'(k), 64'(lat));
        check({tag, "_q"}, quotient, eq);
        check({tag, "_r"}, remainder, er);
        check({tag, "_ready_during_valid"}, 64'(div_ready), 64'd0);
        @(negedge clk);
        check({tag, "_pulse_one_cycle"}, 64'(out_valid), 64'd0);
        check({tag, "_ready_after"}, 64'(div_ready), 64'd1);
        check({tag, "_q_hold_after"}, quotient, eq);
        prev_q = eq;
        prev_r = er;
    endtask

    initial begin
        int accepts, pulses, bad;
        bit seen, prev_ready, prev_ov;
        logic [63:0] ra, rb;
        rst = 1'b1; div_valid = 1'b0; flush = 1'b0; div_signed = 1'b0;
        dividend = 64'd0; divisor = 64'd0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_ready", 64'(div_ready), 64'd1);
        check("reset_valid", 64'(out_valid), 64'd0);
        check("reset_q", quotient, 64'd0);
        check("reset_r", remainder, 64'd0);
        prev_q = 64'd0;
        prev_r = 64'd0;

        run_op(64'd100, 64'd7, 1'b0, "u100_7");
        run_op(-64'sd7, 64'd2, 1'b1, "s_m7_2");
        run_op(-64'sd7, 64'd2, 1'b0, "u_m7_2");
        run_op(64'd5, 64'd0, 1'b1, "s5_0");
        run_op(64'd5, 64'd0, 1'b0, "u5_0");
        run_op(64'h8000_0000_0000_0000, '1, 1'b1, "s_ovf");
        run_op(64'h8000_0000_0000_0000, '1, 1'b0, "u_min_ones");
        run_op(64'd7, -64'sd2, 1'b1, "s7_m2");
        run_op('1, 64'h8000_0000_0000_0001, 1'b0, "u_big");

        // Flush mid-division, then a normal request.
        @(negedge clk);
        dividend = 64'd12345; divisor = 64'd7; div_signed = 1'b0; div_valid = 1'b1;
        @(posedge clk);
        #1 div_valid = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        check("flush_ready", 64'(div_ready), 64'd1);
        seen = 0;
        repeat (80) begin
            @(negedge clk);
            if (out_valid) seen = 1;
        end
        check("flush_no_valid", 64'(seen), 64'd0);
        check("flush_hold_q", quotient, prev_q);
        check("flush_hold_r", remainder, prev_r);

        // Flush and div_valid together in IDLE: no accept.
        @(negedge clk);
        flush = 1'b1; div_valid = 1'b1; dividend = 64'd9; divisor = 64'd3;
        @(posedge clk);
        #1 begin flush = 1'b0; div_valid = 1'b0; end
        @(negedge clk);
        check("flush_blocks_accept", 64'(div_ready), 64'd1);
        run_op(64'd1000, 64'd10, 1'b0, "u1000_10");

        // Reset mid-division.
        @(negedge clk);
        dividend = 64'd999; divisor = 64'd4; div_signed = 1'b0; div_valid = 1'b1;
        @(posedge clk);
        #1 div_valid = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk);
        rst = 1'b1; flush = 1'b1; div_valid = 1'b1;
        @(posedge clk);
        #1 begin rst = 1'b0; flush = 1'b0; div_valid = 1'b0; end
        @(negedge clk);
        check("midrst_ready", 64'(div_ready), 64'd1);
        check("midrst_valid", 64'(out_valid), 64'd0);
        check("midrst_q", quotient, 64'd0);
        check("midrst_r", remainder, 64'd0);
        prev_q = 64'd0;
        prev_r = 64'd0;
        run_op('1, 64'd1, 1'b0, "u_ones_1");

        // Random operands.
        for (int i = 0; i < 20; i++) begin
            ra = {$urandom, $urandom};
            case ($urandom_range(0, 3))
                0:       rb = 64'($urandom_range(0, 20));
                1:       rb = {32'd0, $urandom};
                default: rb = {$urandom, $urandom};
            endcase
            if (i == 5) rb = 64'd0;
            run_op(ra, rb, 1'($urandom), "rand");
        end

        // div_valid held high back to back.
        @(negedge clk);
        dividend = 64'd100; divisor = 64'd7; div_signed = 1'b0; div_valid = 1'b1;
        accepts = 0; pulses = 0; bad = 0;
        prev_ready = 0; prev_ov = 0;
        repeat (300) begin
            if (div_ready) accepts++;
            if (div_ready && prev_ready) bad++;
            if (out_valid) begin
                pulses++;
                if (prev_ov) bad++;
                if (quotient !== 64'd14 || remainder !== 64'd2) bad++;
            end
            prev_ready = div_ready;
            prev_ov = out_valid;
            @(negedge clk);
        end
        div_valid = 1'b0;
        repeat (100) begin
            if (out_valid) begin
                pulses++;
                if (prev_ov) bad++;
            end
            prev_ov = out_valid;
            @(negedge clk);
        end
        check("b2b_violations", 64'(bad), 64'd0);
        check("b2b_accepts_eq_pulses", 64'(pulses), 64'(accepts));
        check("b2b_accept_count", 64'(accepts), 64'd5);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
